// File: rtl/rename_pkg.sv
// Shared defaults, tag/register types and the wakeup bundle for the rename stage.
package rename_pkg;
    localparam int DEFAULT_ARCH_REGS = 32;
    localparam int DEFAULT_PHYS_REGS = 64;
    localparam int DEFAULT_XLEN      = 32;
    localparam int DEFAULT_AW        = $clog2(DEFAULT_ARCH_REGS);
    localparam int DEFAULT_TW        = $clog2(DEFAULT_PHYS_REGS);

    typedef logic [DEFAULT_AW-1:0] arch_reg_t;
    typedef logic [DEFAULT_TW-1:0] phys_tag_t;

    typedef struct packed {
        logic                    active;
        phys_tag_t               tag;
        logic [DEFAULT_XLEN-1:0] value;
    } wakeup_t;

    localparam phys_tag_t ZERO_TAG = '0;
endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags, preloaded with BASE..BASE+DEPTH-1 at reset.
// Head is visible combinationally; pop and push may happen in the same cycle.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int BASE  = 32,
    parameter int TW    = 6,
    parameter int CW    = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pop_i,
    input  logic          push_i,
    input  logic [TW-1:0] push_tag_i,
    output logic [TW-1:0] head_o,
    output logic [CW-1:0] count_o
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [TW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop, do_push;

    // Tag 0 is the permanent x0 mapping and must never re-enter circulation.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (push_tag_i != TW'(ZERO_TAG)) && (count_q != CW'(DEPTH));
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop)
            head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
        if (do_push)
            tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
        if (do_pop && !do_push)
            count_d = count_q - CW'(1);
        else if (do_push && !do_pop)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= TW'(BASE + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
        end else begin
            if (do_push)
                mem_q[tail_q] <= push_tag_i;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (push_tag_i != TW'(ZERO_TAG)) && (count_q == CW'(DEPTH))));
endmodule

// File: rtl/rename_unit.sv
// Register rename stage: RAT, free list and PRF ready/value state with N wakeup ports.
// Rename outputs are combinational; stalls only when a destination needs a tag and none is free.
module rename_unit
    import rename_pkg::*;
#(
    parameter  int ARCH_REGS    = DEFAULT_ARCH_REGS,
    parameter  int PHYS_REGS    = DEFAULT_PHYS_REGS,
    parameter  int XLEN         = DEFAULT_XLEN,
    parameter  int WAKEUP_PORTS = 2,
    localparam int AW           = $clog2(ARCH_REGS),
    localparam int TW           = $clog2(PHYS_REGS),
    localparam int CW           = $clog2(PHYS_REGS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         rd_write,
    input  logic [AW-1:0]                architectural_rd,
    input  logic [AW-1:0]                architectural_rs1,
    input  logic [AW-1:0]                architectural_rs2,
    output logic [TW-1:0]                physical_rd,
    output logic [TW-1:0]                old_physical_rd,
    output logic [TW-1:0]                physical_rs1,
    output logic [TW-1:0]                physical_rs2,
    output logic                         rs1_ready,
    output logic                         rs2_ready,
    output logic [XLEN-1:0]              rs1_value,
    output logic [XLEN-1:0]              rs2_value,
    input  logic [WAKEUP_PORTS-1:0]      wakeup_active,
    input  logic [WAKEUP_PORTS*TW-1:0]   wakeup_tag,
    input  logic [WAKEUP_PORTS*XLEN-1:0] wakeup_value,
    input  logic                         retire_free_valid,
    input  logic [TW-1:0]                retire_free_tag,
    output logic [CW-1:0]                free_count
);
    logic [TW-1:0]        rat_q   [ARCH_REGS];
    logic [PHYS_REGS-1:0] ready_q;
    logic [XLEN-1:0]      value_q [PHYS_REGS];
    logic [TW-1:0]        fl_head;
    logic [CW-1:0]        fl_count;
    logic                 alloc, fire_alloc;

    assign alloc           = rd_write && (architectural_rd != '0);
    assign in_ready        = !alloc || (fl_count != '0);
    assign fire_alloc      = in_valid && in_ready && alloc;
    assign free_count      = fl_count;
    assign physical_rd     = alloc ? fl_head : TW'(ZERO_TAG);
    assign old_physical_rd = rat_q[architectural_rd];
    assign physical_rs1    = rat_q[architectural_rs1];
    assign physical_rs2    = rat_q[architectural_rs2];

    // Descending scan so the lowest matching channel is the last to assign.
    always_comb begin
        rs1_ready = ready_q[physical_rs1];
        rs1_value = value_q[physical_rs1];
        rs2_ready = ready_q[physical_rs2];
        rs2_value = value_q[physical_rs2];
        for (int w = WAKEUP_PORTS - 1; w >= 0; w--) begin
            if (wakeup_active[w] && (wakeup_tag[w*TW +: TW] != TW'(ZERO_TAG))) begin
                if (wakeup_tag[w*TW +: TW] == physical_rs1) begin
                    rs1_ready = 1'b1;
                    rs1_value = wakeup_value[w*XLEN +: XLEN];
                end
                if (wakeup_tag[w*TW +: TW] == physical_rs2) begin
                    rs2_ready = 1'b1;
                    rs2_value = wakeup_value[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Allocation is written after the wakeups so a same-tag collision leaves the tag not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++)
                rat_q[i] <= TW'(i);
            for (int t = 0; t < PHYS_REGS; t++) begin
                ready_q[t] <= (t < ARCH_REGS);
                value_q[t] <= '0;
            end
        end else begin
            for (int w = WAKEUP_PORTS - 1; w >= 0; w--) begin
                if (wakeup_active[w] && (wakeup_tag[w*TW +: TW] != TW'(ZERO_TAG))) begin
                    ready_q[wakeup_tag[w*TW +: TW]] <= 1'b1;
                    value_q[wakeup_tag[w*TW +: TW]] <= wakeup_value[w*XLEN +: XLEN];
                end
            end
            if (fire_alloc) begin
                rat_q[architectural_rd] <= fl_head;
                ready_q[fl_head]        <= 1'b0;
            end
        end
    end

    rename_free_list #(
        .DEPTH (PHYS_REGS - ARCH_REGS),
        .BASE  (ARCH_REGS),
        .TW    (TW),
        .CW    (CW)
    ) u_free_list (
        .clk_i      (clk),
        .rst_i      (reset),
        .pop_i      (fire_alloc),
        .push_i     (retire_free_valid),
        .push_tag_i (retire_free_tag),
        .head_o     (fl_head),
        .count_o    (fl_count)
    );
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
Parametrised register-rename stage for the out-of-order core. It holds the RAT (register alias table), a circular free list and the physical register file (PRF) with per-tag ready bits and values. It renames one instruction per cycle and stalls it when no physical register is free. It also takes N parallel wakeup/writeback channels and returns freed tags from retire. It sits between decode and the reservation stations.

Parameters:
ARCH_REGS, 32, number of architectural registers (x0 hardwired to zero)
PHYS_REGS, 64, number of physical registers; must be greater than ARCH_REGS
XLEN, 32, data width
WAKEUP_PORTS, 2, number of parallel wakeup channels
(derived) AW = clog2(ARCH_REGS), TW = clog2(PHYS_REGS), CW = clog2(PHYS_REGS+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  rename can accept this cycle
rd_write  in  1  instruction writes architectural_rd
architectural_rd  in  AW  destination register
architectural_rs1  in  AW  source 1
architectural_rs2  in  AW  source 2
physical_rd  out  TW  newly allocated tag (0 if no allocation)
old_physical_rd  out  TW  previous mapping of rd, carried to the ROB for freeing at retire
physical_rs1  out  TW  current mapping of rs1
physical_rs2  out  TW  current mapping of rs2
rs1_ready  out  1  rs1 value available
rs2_ready  out  1  rs2 value available
rs1_value  out  XLEN  rs1 value (valid when rs1_ready)
rs2_value  out  XLEN  rs2 value (valid when rs2_ready)
wakeup_active  in  WAKEUP_PORTS  per-channel valid
wakeup_tag  in  WAKEUP_PORTS*TW  packed tags, channel 0 in the LSBs
wakeup_value  in  WAKEUP_PORTS*XLEN  packed values
retire_free_valid  in  1  retire releases a tag
retire_free_tag  in  TW  tag to return to the free list
free_count  out  CW  number of entries currently in the free list

Behaviour:
- Reset (async, immediate):
  - RAT[i] = i for all i.
  - PRF tags 0..ARCH_REGS-1 are ready with value 0; the remaining tags are not ready.
  - Free list holds ARCH_REGS..PHYS_REGS-1 in ascending order; head = first entry, free_count = PHYS_REGS-ARCH_REGS.
- Handshakes:
  - alloc = rd_write && architectural_rd != 0.
  - in_ready = !alloc || free_count != 0.
  - fire = in_valid && in_ready.
- Rename outputs are combinational in the same cycle:
  - physical_rs1/2 = RAT[rs]. Sources always read the pre-update mapping, so rd == rs in one instruction returns the old tag.
  - physical_rd = free-list head when alloc, otherwise 0.
  - old_physical_rd = RAT[rd].
- On a clock edge with fire && alloc:
  - RAT[rd] <= head.
  - ready[head] <= 0.
  - Pop the head.
- x0 always maps to tag 0, which is permanently ready with value 0. Writes to x0 never allocate and never modify the RAT.
- Wakeup, on the clock edge, for each active channel with tag != 0: ready[tag] <= 1 and value[tag] <= wakeup_value.
  - If several channels carry the same tag, the lowest channel index wins.
  - A wakeup on tag 0 is ignored.
- Same-cycle wakeup bypass: rsN_ready/rsN_value reflect any active wakeup matching physical_rsN in the current cycle (lowest channel wins), ORed with the stored state. Latency from wakeup to a visible ready is therefore 0 cycles.
- Retire free, on the clock edge: if retire_free_valid and tag != 0, push the tag at the tail.
  - A push when free_count == PHYS_REGS-ARCH_REGS is a protocol error: simulation assertion fires, the push is dropped.
- Simultaneous push and pop:
  - Head and tail both advance and free_count is unchanged.
  - in_ready uses the registered count; a same-cycle push does not unblock an empty list.
- Wakeup and allocation on the same tag in the same cycle: allocation wins, and ready ends at 0.
- Head and tail pointers wrap modulo (PHYS_REGS-ARCH_REGS).
- When in_valid is 0 or the instruction stalls: no state change besides wakeup and retire.
- Reset mid-operation: all state is restored to the reset state immediately, and any pending allocation is lost.

Decomposition:
- Package rename_pkg holds:
  - the default ARCH_REGS, PHYS_REGS and XLEN;
  - the arch_reg_t and phys_tag_t typedefs;
  - the wakeup_t struct {active, tag, value};
  - the ZERO_TAG constant.
- Sub-module rename_free_list: a circular FIFO of tags with pop, push, count and head outputs and the reset init sequence. The RAT, PRF and bypass logic stay in rename_unit.

Test Plan:
- Reset, then rename add x1,x0,x1 -> physical_rd=32, physical_rs2=1, rs1/rs2 ready with value 0, free_count 32→31 after the edge.
- Second add x1,x0,x1 -> physical_rs2=32 and not ready, physical_rd=33, old_physical_rd=32.
- Wakeup tag 33 value 456 on channel 1 while renaming a reader of x1 -> rs2_ready=1 and rs2_value=456 in the same cycle; still ready with no wakeup on the next cycle.
- Ports 0 and 1 both wake tag 40 with values 7 and 9 -> stored value 7.
- Allocate 32 times with no retire -> free_count=0, in_ready=0 for rd=x5, in_ready=1 for rd=x0. Retire tag 1 -> the next cycle allocates tag 1 for x5.
- Assert reset after several renames -> RAT is identity, free_count=32, next allocation returns tag 32.
